// File: rtl/azadi_pinmux_pkg.sv
// Shared constants, reset values and select-width helper for the pad mux.
// Word-index map: SEL[i] at 0..NUM_PADS-1, DBNC at 62, LOCK at 63.
package azadi_pinmux_pkg;

  localparam int PINMUX_NUM_FUNCS = 4;

  localparam logic [5:0] PINMUX_DBNC_IDX = 6'd62;
  localparam logic [5:0] PINMUX_LOCK_IDX = 6'd63;

  localparam logic PINMUX_LOCK_RST = 1'b0;
  localparam logic PINMUX_OUT_RST  = 1'b0;
  localparam logic PINMUX_OEB_RST  = 1'b1;

  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef logic [sel_width(PINMUX_NUM_FUNCS)-1:0] pinmux_sel_t;

endpackage

// File: rtl/azadi_pinmux_in.sv
// One pad input: 2-flop synchroniser, then optional debounce filter.
// Ports: clk_i, rst_ni, pad_i (raw), dbnc_i (threshold), in_o (clean).
// Debounce present only with AZADI_PINMUX_DEBOUNCE_EN defined.
module azadi_pinmux_in #(
  parameter int DBNC_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pad_i,
  input  logic [DBNC_W-1:0] dbnc_i,
  output logic              in_o
);

  logic [1:0] sync_q;
  logic       s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[0], pad_i};
  end

  assign s = sync_q[1];

`ifdef AZADI_PINMUX_DEBOUNCE_EN
  logic              q_q;
  logic [DBNC_W-1:0] cnt_q;
  logic [DBNC_W-1:0] thr;

  // A threshold of 0 behaves like 1; >= lets a lowered
  // threshold end an in-flight count immediately.
  assign thr = (dbnc_i == '0) ? '0 : dbnc_i - DBNC_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q   <= 1'b0;
      cnt_q <= '0;
    end else if (s == q_q) begin
      cnt_q <= '0;
    end else if (cnt_q >= thr) begin
      q_q   <= s;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DBNC_W'(1);
    end
  end

  assign in_o = q_q;
`else
  logic unused_dbnc;
  assign unused_dbnc = ^dbnc_i;
  assign in_o = s;
`endif

endmodule

// File: rtl/azadi_pinmux.sv
// Register-programmable pad mux: per-pad function select, synchronised
// and optionally debounced inputs (AZADI_PINMUX_DEBOUNCE_EN), sticky lock.
// Ports: clk_i/rst_ni, reg_* access bus with 1-cycle ack, periph_* side,
// pad_* side, lock_o status.
module azadi_pinmux
  import azadi_pinmux_pkg::*;
#(
  parameter int NUM_PADS  = 38,
  parameter int NUM_FUNCS = 4,
  parameter int DBNC_W    = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          reg_req_i,
  input  logic                          reg_we_i,
  input  logic [7:0]                    reg_addr_i,
  input  logic [31:0]                   reg_wdata_i,
  output logic [31:0]                   reg_rdata_o,
  output logic                          reg_ack_o,
  input  logic [NUM_FUNCS*NUM_PADS-1:0] periph_out_i,
  input  logic [NUM_FUNCS*NUM_PADS-1:0] periph_oe_i,
  output logic [NUM_PADS-1:0]           periph_in_o,
  input  logic [NUM_PADS-1:0]           pad_in_i,
  output logic [NUM_PADS-1:0]           pad_out_o,
  output logic [NUM_PADS-1:0]           pad_oeb_o,
  output logic                          lock_o
);

  localparam int SW = sel_width(NUM_FUNCS);

  logic [SW-1:0]     sel_q [NUM_PADS];
  logic [DBNC_W-1:0] dbnc_q;
  logic              lock_q;
  logic              ack_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_d;
  logic [5:0]        idx;
  logic              accept;
  logic              wr;
  logic [NUM_PADS-1:0] out_d;
  logic [NUM_PADS-1:0] oe_d;
  logic              unused_bits;

  assign idx    = reg_addr_i[7:2];
  assign accept = reg_req_i & ~ack_q;
  assign wr     = accept & reg_we_i & ~lock_q;

  assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i};

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_PADS; i++)
      if (idx == 6'(i)) rdata_d = 32'(sel_q[i]);
`ifdef AZADI_PINMUX_DEBOUNCE_EN
    if (idx == PINMUX_DBNC_IDX) rdata_d = 32'(dbnc_q);
`endif
    if (idx == PINMUX_LOCK_IDX) rdata_d = {31'b0, lock_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      lock_q  <= PINMUX_LOCK_RST;
      for (int i = 0; i < NUM_PADS; i++) sel_q[i] <= '0;
`ifdef AZADI_PINMUX_DEBOUNCE_EN
      dbnc_q  <= '0;
`endif
    end else begin
      ack_q   <= accept;
      rdata_q <= (accept & ~reg_we_i) ? rdata_d : '0;
      if (accept & reg_we_i & (idx == PINMUX_LOCK_IDX) & reg_wdata_i[0])
        lock_q <= 1'b1;
      for (int i = 0; i < NUM_PADS; i++)
        if (wr && idx == 6'(i)) sel_q[i] <= reg_wdata_i[SW-1:0];
`ifdef AZADI_PINMUX_DEBOUNCE_EN
      if (wr && idx == PINMUX_DBNC_IDX)
        dbnc_q <= reg_wdata_i[DBNC_W-1:0];
`endif
    end
  end

`ifndef AZADI_PINMUX_DEBOUNCE_EN
  assign dbnc_q = '0;
`endif

  always_comb begin
    out_d = '0;
    oe_d  = '0;
    for (int i = 0; i < NUM_PADS; i++)
      for (int f = 0; f < NUM_FUNCS; f++)
        if (sel_q[i] == SW'(f)) begin
          out_d[i] = periph_out_i[f*NUM_PADS+i];
          oe_d[i]  = periph_oe_i[f*NUM_PADS+i];
        end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_out_o <= {NUM_PADS{PINMUX_OUT_RST}};
      pad_oeb_o <= {NUM_PADS{PINMUX_OEB_RST}};
    end else begin
      pad_out_o <= out_d;
      pad_oeb_o <= ~oe_d;
    end
  end

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_in
    azadi_pinmux_in #(
      .DBNC_W(DBNC_W)
    ) u_in (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .pad_i (pad_in_i[i]),
      .dbnc_i(dbnc_q),
      .in_o  (periph_in_o[i])
    );
  end

  assign reg_ack_o   = ack_q;
  assign reg_rdata_o = rdata_q;
  assign lock_o      = lock_q;

endmodule

// File: tb/tb_azadi_pinmux.sv
// Directed self-checking bench for azadi_pinmux (38 pads, 4 functions).
// Expected debounce latencies follow AZADI_PINMUX_DEBOUNCE_EN.
module tb_azadi_pinmux;

  localparam int NP = 38;
  localparam int NF = 4;
  localparam int NW = NP * NF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [7:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ack;
  logic [NW-1:0] p_out = '0;
  logic [NW-1:0] p_oe = '0;
  logic [NP-1:0] p_in;
  logic [NP-1:0] pad_in = '0;
  logic [NP-1:0] pad_out;
  logic [NP-1:0] pad_oeb;
  logic          lock;

  int checks = 0;
  int errors = 0;

`ifdef AZADI_PINMUX_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  always #5 clk = ~clk;

  azadi_pinmux #(
    .NUM_PADS(NP), .NUM_FUNCS(NF), .DBNC_W(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .reg_req_i(req), .reg_we_i(we),
    .reg_addr_i(addr), .reg_wdata_i(wdata),
    .reg_rdata_o(rdata), .reg_ack_o(ack),
    .periph_out_i(p_out), .periph_oe_i(p_oe),
    .periph_in_o(p_in), .pad_in_i(pad_in),
    .pad_out_o(pad_out), .pad_oeb_o(pad_oeb),
    .lock_o(lock)
  );

  task automatic bus(input logic w, input logic [5:0] idx,
                     input logic [31:0] wd,
                     output logic [31:0] rd, output logic ak);
    @(negedge clk);
    req = 1'b1; we = w; addr = {idx, 2'b00}; wdata = wd;
    @(negedge clk);
    ak = ack; rd = rdata;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic ak;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pad_oeb !== {NP{1'b1}}) begin
      errors++; $display("FAIL rst_oeb got %h want all ones", pad_oeb);
    end
    checks++;
    if (pad_out !== '0) begin
      errors++; $display("FAIL rst_out got %h want 0", pad_out);
    end
    checks++;
    if (p_in !== '0) begin
      errors++; $display("FAIL rst_pin got %h want 0", p_in);
    end
    checks++;
    if (lock !== 1'b0 || ack !== 1'b0 || rdata !== '0) begin
      errors++;
      $display("FAIL rst_regs lock %b ack %b rdata %h want 0 0 0", lock, ack, rdata);
    end
    bus(1'b0, 6'd0, '0, rd, ak);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd0) begin
      errors++; $display("FAIL rst_read0 ack %b data %h want 1 0", ak, rd);
    end
  endtask

  task automatic test_sel();
    logic [31:0] rd;
    logic ak;
    logic [NP-1:0] eo, eb;
    p_out = '0; p_oe = '0;
    p_out[2*NP+5] = 1'b1;
    p_oe[2*NP+5]  = 1'b1;
    p_out[7]      = 1'b1;
    p_out[NP+9]   = 1'b1;
    bus(1'b1, 6'd5, 32'd2, rd, ak);
    checks++;
    if (ak !== 1'b1) begin
      errors++; $display("FAIL sel_wr_ack got %b want 1", ak);
    end
    @(negedge clk);
    eo = '0; eo[5] = 1'b1; eo[7] = 1'b1;
    eb = '1; eb[5] = 1'b0;
    checks++;
    if (pad_out !== eo) begin
      errors++; $display("FAIL sel_out got %h want %h", pad_out, eo);
    end
    checks++;
    if (pad_oeb !== eb) begin
      errors++; $display("FAIL sel_oeb got %h want %h", pad_oeb, eb);
    end
    bus(1'b0, 6'd5, '0, rd, ak);
    checks++;
    if (rd !== 32'd2) begin
      errors++; $display("FAIL sel_rd5 got %h want 2", rd);
    end
    bus(1'b1, 6'd6, 32'hFFFF_FFF6, rd, ak);
    bus(1'b0, 6'd6, '0, rd, ak);
    checks++;
    if (rd !== 32'd2) begin
      errors++; $display("FAIL sel_trunc got %h want 2", rd);
    end
  endtask

  task automatic test_debounce();
    logic [31:0] rd;
    logic ak;
    bit seen;
    int lat;
    bus(1'b1, 6'd62, 32'd4, rd, ak);
    bus(1'b0, 6'd62, '0, rd, ak);
    checks++;
    if (rd !== (DB ? 32'd4 : 32'd0)) begin
      errors++; $display("FAIL dbnc_rd got %h want %h", rd, DB ? 4 : 0);
    end
    @(negedge clk);
    pad_in[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (p_in[0]) seen = 1'b1;
    end
    pad_in[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (p_in[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== !DB) begin
      errors++; $display("FAIL dbnc_glitch passed %b want %b", seen, !DB);
    end
    repeat (4) @(negedge clk);
    pad_in[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (lat == 0 && p_in[0]) lat = k;
    end
    checks++;
    if (lat != (DB ? 6 : 2)) begin
      errors++; $display("FAIL dbnc_lat got %0d want %0d", lat, DB ? 6 : 2);
    end
    bus(1'b1, 6'd62, 32'd0, rd, ak);
    @(negedge clk);
    pad_in[1] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (lat == 0 && p_in[1]) lat = k;
    end
    checks++;
    if (lat != (DB ? 3 : 2)) begin
      errors++; $display("FAIL dbnc0_lat got %0d want %0d", lat, DB ? 3 : 2);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    logic ak;
    bus(1'b1, 6'd40, 32'hFFFF_FFFF, rd, ak);
    checks++;
    if (ak !== 1'b1) begin
      errors++; $display("FAIL unmap_wr_ack got %b want 1", ak);
    end
    bus(1'b0, 6'd40, '0, rd, ak);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd0) begin
      errors++; $display("FAIL unmap_rd ack %b data %h want 1 0", ak, rd);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic prev;
    bit dbl;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 8'd20;
    pulses = 0; prev = 1'b0; dbl = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack) pulses++;
      if (ack && prev) dbl = 1'b1;
      prev = ack;
    end
    req = 1'b0;
    checks++;
    if (pulses != 3 || dbl) begin
      errors++; $display("FAIL b2b_acks got %0d double %b want 3 0", pulses, dbl);
    end
  endtask

  task automatic test_lock();
    logic [31:0] rd;
    logic ak;
    bus(1'b1, 6'd63, 32'd1, rd, ak);
    checks++;
    if (ak !== 1'b1 || lock !== 1'b1) begin
      errors++; $display("FAIL lock_set ack %b lock %b want 1 1", ak, lock);
    end
    bus(1'b1, 6'd3, 32'd1, rd, ak);
    checks++;
    if (ak !== 1'b1) begin
      errors++; $display("FAIL lock_wr_ack got %b want 1", ak);
    end
    bus(1'b0, 6'd3, '0, rd, ak);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL lock_sel3 got %h want 0", rd);
    end
    bus(1'b1, 6'd62, 32'd7, rd, ak);
    bus(1'b0, 6'd62, '0, rd, ak);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL lock_dbnc got %h want 0", rd);
    end
    bus(1'b1, 6'd63, 32'd0, rd, ak);
    bus(1'b0, 6'd63, '0, rd, ak);
    checks++;
    if (lock !== 1'b1 || rd !== 32'd1) begin
      errors++; $display("FAIL lock_sticky lock %b rd %h want 1 1", lock, rd);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 8'd20;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (lock !== 1'b0 || pad_oeb !== {NP{1'b1}} || pad_out !== '0) begin
      errors++;
      $display("FAIL async_rst lock %b oeb %h out %h", lock, pad_oeb, pad_out);
    end
    checks++;
    if (p_in !== '0 || ack !== 1'b0) begin
      errors++; $display("FAIL async_rst_in pin %h ack %b want 0 0", p_in, ack);
    end
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sel();
    test_debounce();
    test_unmapped();
    test_back_to_back();
    test_lock();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
